main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port op  input  7  instruction opcode field (instr[6:0]).
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have ports pc_write, adr_src, mem_write, ir_write, reg_write  output  1 each  datapath enables/selects.
REQ-007 SHALL have ports result_src, alu_src_a, alu_src_b, alu_op  output  2 each  datapath mux selects; alu_op feeds the ALU decoder.
REQ-008 SHALL have port illegal_instr  output  1  high while in TRAP.
REQ-009 SHALL have port instr_count  output  CNT_W  retired-instruction count.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP; one transition per clock.
REQ-011 SHALL transition: FETCH->DECODE unconditionally.
REQ-012 SHALL transition from DECODE by op: 0000011 or 0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1100011->BEQ; 1101111->JAL; any other->TRAP.
REQ-013 SHALL transition: MEMADR->MEMREAD if op=0000011, else MEMWRITE; MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-014 SHALL hold TRAP until reset; illegal_instr=1 only in TRAP, all write enables 0 in TRAP.
REQ-015 SHALL drive per state (unlisted outputs 0): FETCH ir_write=1, alu_src_b=10, result_src=10, PC update=1; DECODE alu_src_a=01, alu_src_b=01; MEMADR alu_src_a=10, alu_src_b=01; MEMREAD adr_src=1; MEMWB result_src=01, reg_write=1; MEMWRITE adr_src=1, mem_write=1; EXECUTER alu_src_a=10, alu_op=10; EXECUTEI alu_src_a=10, alu_src_b=01, alu_op=10; ALUWB reg_write=1; JAL alu_src_a=01, alu_src_b=10, PC update=1; BEQ alu_src_a=10, alu_op=01, branch=1.
REQ-016 SHALL compute pc_write = PC update | (branch & zero), combinationally from state and zero (only non-Moore output).
REQ-017 SHALL increment instr_count by 1 on each clock edge where state is MEMWB, MEMWRITE, ALUWB or BEQ (instruction retire); BEQ counts whether taken or not.
REQ-018 SHALL wrap instr_count from 2^CNT_W-1 to 0 with no flag.
REQ-019 SHALL ignore op changes outside DECODE and MEMADR; op sampled only on those edges.
REQ-020 SHALL decode lw in 5 cycles, sw 4, R/I-type 4, jal 4, beq 3 (FETCH-inclusive).

Reset
REQ-021 SHALL on rst_n=0 asynchronously force state=FETCH, instr_count=0, illegal_instr=0.
REQ-022 SHALL, while in reset, present FETCH outputs (ir_write=1, pc_write=1); datapath registers gate on their own reset.
REQ-023 SHALL, on reset mid-instruction, abandon the instruction without counting it; first post-reset edge goes FETCH->DECODE.
REQ-024 SHALL exit TRAP only via reset.

Structure
REQ-025 SHALL place opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL), state encoding, and 2-bit select encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10) in shared package riscv_ctrl_pkg.
REQ-026 SHALL be a single module; state register, next-state logic, output decode and counter in one file; no sub-module.

Verification
REQ-027 SHALL test lw: reset release, op=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; reg_write=1 only in MEMWB with result_src=01; instr_count 0->1.
REQ-028 SHALL test beq taken/not: op=1100011, zero=1 in BEQ -> pc_write=1 with alu_op=01; zero=0 -> pc_write=0; both increment instr_count.
REQ-029 SHALL test illegal op=1111111 in DECODE -> TRAP next cycle, illegal_instr=1, reg_write=mem_write=pc_write=0 for 20 cycles, instr_count frozen.
REQ-030 SHALL test async reset: assert rst_n=0 mid-MEMREAD between edges -> state FETCH immediately, instr_count=0, no retire counted.
REQ-031 SHALL test wrap: CNT_W=4, retire 16 R-type (op=0110011) -> instr_count 15->0; each R-type shows EXECUTER alu_op=10, alu_src_a=10, alu_src_b=00.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V main controller:
// opcodes, FSM state encoding and datapath mux select codes.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // States whose outgoing edge completes an instruction.
  function automatic logic is_retire(state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) || (s == S_BEQ);
  endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: Moore FSM driving datapath enables and
// selects, plus a retired-instruction counter.
module main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        op,
  input  logic              zero,
  output logic              pc_write,
  output logic              adr_src,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              illegal_instr,
  output logic [CNT_W-1:0]  instr_count
);

  state_t state;
  state_t next_state;
  logic   pc_update;
  logic   branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state and Moore output decode.
  always_comb begin
    next_state    = state;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;
    unique case (state)
      S_FETCH: begin
        next_state = S_DECODE;
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW || op == OP_SW) next_state = S_MEMADR;
        else if (op == OP_R)            next_state = S_EXECUTER;
        else if (op == OP_I)            next_state = S_EXECUTEI;
        else if (op == OP_BEQ)          next_state = S_BEQ;
        else if (op == OP_JAL)          next_state = S_JAL;
        else                            next_state = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a  = SRCA_REG;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_REG;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
        next_state    = S_TRAP;
      end
      default: next_state = S_TRAP;
    endcase
  end

  // Only output that depends on an input: branch resolution uses the ALU flag.
  assign pc_write = pc_update | (branch & zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               instr_count <= '0;
    else if (is_retire(state)) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus queues hand-derived per-cycle
// expectations, a monitor pops and compares them on the falling edge.
module tb_main_fsm;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  typedef enum {
    X_FETCH, X_DECODE, X_MEMADR, X_MEMREAD, X_MEMWB, X_MEMWRITE,
    X_EXECUTER, X_EXECUTEI, X_ALUWB, X_BEQ, X_JAL, X_TRAP
  } tst_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t       o;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] instr_count;

  exp_t       q[$];
  event       chk_ev;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;
  out_t       act;

  always #5 clk = ~clk;

  main_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .instr_count(instr_count)
  );

  assign act = {pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

  function automatic out_t expect_out(tst_t s, logic z);
    out_t o = '0;
    case (s)
      X_FETCH:    begin o.ir_write = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10; o.pc_write = 1; end
      X_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      X_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      X_MEMREAD:  o.adr_src = 1;
      X_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1; end
      X_MEMWRITE: begin o.adr_src = 1; o.mem_write = 1; end
      X_EXECUTER: begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
      X_EXECUTEI: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
      X_ALUWB:    o.reg_write = 1;
      X_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1; end
      X_BEQ:      begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = z; end
      X_TRAP:     o.illegal = 1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  // Monitor: compares every queued expectation on the falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (act !== e.o || instr_count !== e.cnt) begin
          errors++;
          $display("FAIL %s: got outputs=%h count=%0d, expected outputs=%h count=%0d",
                   e.name, act, instr_count, e.o, e.cnt);
        end
      end
    end
  end

  // One clock cycle spent in state s; called just after a rising edge.
  task automatic cycle(input tst_t s, input logic [6:0] o, input logic z, input string nm);
    op   = o;
    zero = z;
    q.push_back('{expect_out(s, z), exp_cnt, nm});
    @(posedge clk);
    #1;
    if (rst_n && (s == X_MEMWB || s == X_MEMWRITE || s == X_ALUWB || s == X_BEQ))
      exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: FETCH outputs, counter zero.
    cycle(X_FETCH, T_R, 1'b0, "reset_fetch0");
    cycle(X_FETCH, T_BAD, 1'b1, "reset_fetch1");
    rst_n = 1'b1;

    // lw with junk op outside DECODE/MEMADR.
    cycle(X_FETCH,   T_BAD, 1'b0, "lw_fetch");
    cycle(X_DECODE,  T_LW,  1'b0, "lw_decode");
    cycle(X_MEMADR,  T_LW,  1'b0, "lw_memadr");
    cycle(X_MEMREAD, T_BAD, 1'b0, "lw_memread");
    cycle(X_MEMWB,   T_BAD, 1'b0, "lw_memwb");

    cycle(X_FETCH,    T_SW, 1'b0, "sw_fetch");
    cycle(X_DECODE,   T_SW, 1'b0, "sw_decode");
    cycle(X_MEMADR,   T_SW, 1'b0, "sw_memadr");
    cycle(X_MEMWRITE, T_LW, 1'b0, "sw_memwrite");

    cycle(X_FETCH,    T_I, 1'b0, "i_fetch");
    cycle(X_DECODE,   T_I, 1'b0, "i_decode");
    cycle(X_EXECUTEI, T_R, 1'b0, "i_executei");
    cycle(X_ALUWB,    T_R, 1'b0, "i_aluwb");

    cycle(X_FETCH,  T_JAL, 1'b0, "jal_fetch");
    cycle(X_DECODE, T_JAL, 1'b1, "jal_decode");
    cycle(X_JAL,    T_BAD, 1'b0, "jal_jal");
    cycle(X_ALUWB,  T_BAD, 1'b0, "jal_aluwb");

    cycle(X_FETCH,  T_BEQ, 1'b1, "beq_t_fetch");
    cycle(X_DECODE, T_BEQ, 1'b1, "beq_t_decode");
    cycle(X_BEQ,    T_BAD, 1'b1, "beq_taken");
    cycle(X_FETCH,  T_BEQ, 1'b0, "beq_n_fetch");
    cycle(X_DECODE, T_BEQ, 1'b0, "beq_n_decode");
    cycle(X_BEQ,    T_BAD, 1'b0, "beq_not_taken");

    // Async reset asserted between edges while in MEMREAD.
    cycle(X_FETCH,  T_LW, 1'b0, "ar_fetch");
    cycle(X_DECODE, T_LW, 1'b0, "ar_decode");
    cycle(X_MEMADR, T_LW, 1'b0, "ar_memadr");
    q.push_back('{expect_out(X_MEMREAD, 1'b0), exp_cnt, "ar_memread"});
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_cnt = 4'd0;
    #1;
    q.push_back('{expect_out(X_FETCH, 1'b0), exp_cnt, "ar_async_fetch"});
    -> chk_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(X_FETCH,  T_R, 1'b0, "ar_post_fetch");
    cycle(X_DECODE, T_R, 1'b0, "ar_post_decode");
    cycle(X_EXECUTER, T_R, 1'b0, "ar_post_exec");
    cycle(X_ALUWB,  T_R, 1'b0, "ar_post_aluwb");

    // Counter wrap: 16 more R-type retires from 1 ends at 1; total 17 crosses 15->0.
    for (int i = 0; i < 16; i++) begin
      cycle(X_FETCH,    T_R, 1'b0, $sformatf("r%0d_fetch", i));
      cycle(X_DECODE,   T_R, 1'b0, $sformatf("r%0d_decode", i));
      cycle(X_EXECUTER, T_R, 1'b1, $sformatf("r%0d_executer", i));
      cycle(X_ALUWB,    T_R, 1'b0, $sformatf("r%0d_aluwb", i));
    end
    cycle(X_FETCH, T_BAD, 1'b0, "post_wrap_fetch");

    // Illegal opcode: TRAP held regardless of op/zero.
    cycle(X_DECODE, T_BAD, 1'b0, "ill_decode");
    for (int i = 0; i < 20; i++)
      cycle(X_TRAP, (i % 2 == 0) ? T_R : T_LW, 1'b1, $sformatf("trap%0d", i));

    // Only reset leaves TRAP.
    rst_n = 1'b0;
    exp_cnt = 4'd0;
    cycle(X_FETCH, T_R, 1'b0, "trap_reset");
    rst_n = 1'b1;
    cycle(X_FETCH,  T_R, 1'b0, "exit_fetch");
    cycle(X_DECODE, T_R, 1'b0, "exit_decode");
    cycle(X_EXECUTER, T_R, 1'b0, "exit_executer");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
